// File: rtl/song_recorder.sv
// song_recorder: turns a live tone stream into {duration, tone} entries written to song RAM.
// Optional end-of-song 0x00 terminator via SONG_RECORDER_END_MARK_EN.
module song_recorder #(
  parameter int TICK_DIV = 12_500_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] tone_in,
  input  logic       rec_start,
  input  logic       rec_stop,
  output logic       mem_we,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_din,
  output logic       recording,
  output logic       full,
  output logic [8:0] note_count
);
  localparam int TW = $clog2(TICK_DIV);
`ifdef SONG_RECORDER_END_MARK_EN
  localparam logic [7:0] LAST = 8'd254;
  typedef enum logic [1:0] {IDLE, REC, FLUSH, MARK} state_t;
`else
  localparam logic [7:0] LAST = 8'd255;
  typedef enum logic [1:0] {IDLE, REC, FLUSH} state_t;
`endif
  state_t state;
  logic [3:0] held_tone, dur_cnt;
  logic [TW-1:0] tick_cnt;
  logic [7:0] wr_addr;
  logic wrap, sat, chg, note_wr;
  // A saturating note always has dur_cnt == 15, so dur_cnt is the entry duration in every case.
  always_comb begin
    wrap = tick_cnt == TW'(TICK_DIV - 1);
    sat = wrap && (&dur_cnt);
    chg = tone_in != held_tone;
    note_wr = state == REC && ((rec_stop || chg) ? |dur_cnt : sat);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      mem_we <= 1'b0;
      mem_addr <= 8'd0;
      mem_din <= 8'd0;
      recording <= 1'b0;
      full <= 1'b0;
      note_count <= 9'd0;
      held_tone <= 4'd0;
      dur_cnt <= 4'd0;
      tick_cnt <= '0;
      wr_addr <= 8'd0;
    end else begin
      mem_we <= note_wr;
      mem_addr <= wr_addr;
      if (note_wr) begin
        mem_din <= {dur_cnt, held_tone};
        wr_addr <= wr_addr + {7'd0, wr_addr != 8'hFF};
        note_count <= note_count + 9'd1;
        full <= full | (wr_addr == LAST);
      end
      case (state)
        IDLE: if (rec_start) begin
          state <= REC;
          recording <= 1'b1;
          wr_addr <= 8'd0;
          note_count <= 9'd0;
          full <= 1'b0;
          dur_cnt <= 4'd0;
          tick_cnt <= '0;
          held_tone <= tone_in;
        end
        REC: begin
          tick_cnt <= wrap ? '0 : tick_cnt + TW'(1);
          dur_cnt <= dur_cnt + {3'd0, wrap};
          if (rec_stop || (note_wr && wr_addr == LAST)) state <= FLUSH;
          else if (chg || sat) begin
            held_tone <= tone_in;
            dur_cnt <= 4'd0;
            tick_cnt <= '0;
          end
        end
`ifdef SONG_RECORDER_END_MARK_EN
        FLUSH: begin
          mem_we <= 1'b1;
          mem_din <= 8'h00;
          state <= MARK;
        end
        MARK: begin
          state <= IDLE;
          recording <= 1'b0;
        end
`else
        FLUSH: begin
          state <= IDLE;
          recording <= 1'b0;
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end
endmodule
